// File: rtl/fsm_burst_reader.sv
// Burst read controller: on go, issues 1..BURST_LEN reads at incrementing addresses,
// waits out memory wait-states per beat, and aborts with an error strobe on timeout.
module fsm_burst_reader #(
    parameter int ADDR_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int MAX_WAIT  = 15,
    localparam int LEN_W    = $clog2(BURST_LEN + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  beats,
    input  logic              ws,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic              beat,
    output logic              ds,
    output logic              err,
    output logic              busy
);

    // A zero MAX_WAIT disables the timeout; the counter still needs at least one bit.
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT < 1) ? '0 : WAIT_W'(MAX_WAIT - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DELAY,
        DONE,
        ERR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   remaining_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_next;
    logic               beat_next;

    always_comb begin
        state_next     = state;
        addr_next      = addr;
        remaining_next = remaining;
        wait_next      = wait_cnt;
        beat_next      = 1'b0;
        case (state)
            IDLE: begin
                if (go && beats != '0) begin
                    state_next     = READ;
                    addr_next      = base_addr;
                    remaining_next = (beats > LEN_MAX) ? LEN_MAX : beats;
                end
            end
            READ: begin
                state_next = DELAY;
                wait_next  = '0;
            end
            DELAY: begin
                if (!ws) begin
                    beat_next      = 1'b1;
                    remaining_next = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                        addr_next  = addr + ADDR_W'(1);
                    end
                end else if (MAX_WAIT != 0) begin
                    // wait_cnt holds the ws-high cycles already seen, so this one is the last allowed
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = ERR;
                    end else begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            rd        <= 1'b0;
            beat      <= 1'b0;
            ds        <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            remaining <= remaining_next;
            wait_cnt  <= wait_next;
            rd        <= (state_next == READ) || (state_next == DELAY);
            beat      <= beat_next;
            ds        <= (state_next == DONE);
            err       <= (state_next == ERR);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_fsm_burst_reader.sv
// Self-checking bench for fsm_burst_reader: each burst is expanded into a cycle-by-cycle
// expected output trace from its beat count and per-beat wait-state counts.
module tb_fsm_burst_reader;

    localparam int MAX_WAIT = 15;
    localparam int NONE     = 1000;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] base_addr;
    logic [2:0] beats;
    logic       ws;
    logic       rd;
    logic [7:0] addr;
    logic       beat;
    logic       ds;
    logic       err;
    logic       busy;

    fsm_burst_reader #(.ADDR_W(8), .BURST_LEN(4), .MAX_WAIT(MAX_WAIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .base_addr (base_addr),
        .beats     (beats),
        .ws        (ws),
        .rd        (rd),
        .addr      (addr),
        .beat      (beat),
        .ds        (ds),
        .err       (err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic       beat;
        logic       ds;
        logic       err;
        logic       busy;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         compared   = 0;
    int         mismatched = 0;
    int         beats_seen;
    int         ds_seen;
    int         err_seen;
    int         busy_seen;
    logic [7:0] addr_seen[$];
    logic       prev_rd;
    logic [7:0] prev_addr;

    function automatic exp_t mk(logic r, logic [7:0] a, logic bt, logic d, logic e, logic b);
        exp_t x;
        x.rd   = r;
        x.addr = a;
        x.beat = bt;
        x.ds   = d;
        x.err  = e;
        x.busy = b;
        return x;
    endfunction

    // Compare process: one expected entry per clock edge, checked at the following negedge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            compared++;
            if (rd !== cur.rd || beat !== cur.beat || ds !== cur.ds || err !== cur.err ||
                busy !== cur.busy || (cur.rd && addr !== cur.addr)) begin
                mismatched++;
                $display("[TB] FAIL cycle_check t=%0t got rd=%b addr=%h beat=%b ds=%b err=%b busy=%b want rd=%b addr=%h beat=%b ds=%b err=%b busy=%b",
                         $time, rd, addr, beat, ds, err, busy,
                         cur.rd, cur.addr, cur.beat, cur.ds, cur.err, cur.busy);
            end
        end
        if (beat === 1'b1) beats_seen++;
        if (ds === 1'b1)   ds_seen++;
        if (err === 1'b1)  err_seen++;
        if (busy === 1'b1) busy_seen++;
        if (rd === 1'b1 && (prev_rd !== 1'b1 || addr !== prev_addr)) addr_seen.push_back(addr);
        prev_rd   = rd;
        prev_addr = addr;
    end

    task automatic applyStimulus(input logic r, input logic g, input logic [7:0] b,
                                 input logic [2:0] n, input logic w, input exp_t e);
        reset     = r;
        go        = g;
        base_addr = b;
        beats     = n;
        ws        = w;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic clearStats();
        beats_seen = 0;
        ds_seen    = 0;
        err_seen   = 0;
        busy_seen  = 0;
        addr_seen.delete();
    endtask

    // go_at < 0 pulses go on the edge where the burst is finishing (DONE/ERR).
    task automatic runBurst(input logic [7:0] base, input logic [2:0] nb,
                            input int w0, input int w1, input int w2, input int w3,
                            input int go_at, input int reset_at);
        exp_t       eq[$];
        logic       wsq[$];
        int         w[4];
        int         n;
        int         go_idx;
        logic [7:0] a;
        bit         aborted;
        exp_t       idle_e;
        idle_e  = mk(0, 8'h00, 0, 0, 0, 0);
        w       = '{w0, w1, w2, w3};
        n       = (nb > 3'd4) ? 4 : int'(nb);
        a       = base;
        aborted = 0;
        clearStats();
        if (n == 0) begin
            eq.push_back(idle_e);
            wsq.push_back(1'b0);
        end else begin
            eq.push_back(mk(1, a, 0, 0, 0, 1));
            wsq.push_back(1'b0);
            for (int i = 0; i < n && !aborted; i++) begin
                eq.push_back(mk(1, a, 0, 0, 0, 1));
                wsq.push_back(1'b0);
                for (int h = 1; h <= w[i] && !aborted; h++) begin
                    if (h == MAX_WAIT) begin
                        eq.push_back(mk(0, a, 0, 0, 1, 1));
                        aborted = 1;
                    end else begin
                        eq.push_back(mk(1, a, 0, 0, 0, 1));
                    end
                    wsq.push_back(1'b1);
                end
                if (!aborted) begin
                    if (i == n - 1) begin
                        eq.push_back(mk(0, a, 1, 1, 0, 1));
                    end else begin
                        a = a + 8'd1;
                        eq.push_back(mk(1, a, 1, 0, 0, 1));
                    end
                    wsq.push_back(1'b0);
                end
            end
            eq.push_back(idle_e);
            wsq.push_back(1'b0);
        end
        go_idx = (go_at < 0) ? eq.size() - 1 : go_at;
        for (int k = 0; k < eq.size(); k++) begin
            if (k == reset_at) begin
                applyStimulus(1, 0, 8'h00, 3'd0, 1'b0, idle_e);
                break;
            end
            applyStimulus(0, (k == 0) || (k == go_idx),
                          (k == 0) ? base : 8'h55, (k == 0) ? nb : 3'd1, wsq[k], eq[k]);
        end
        applyStimulus(0, 0, 8'h00, 3'd0, 1'b0, idle_e);
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        go        = 1'b0;
        ws        = 1'b0;
        base_addr = 8'h00;
        beats     = 3'd0;
        clearStats();
        applyStimulus(1, 0, 8'h00, 3'd0, 1'b0, mk(0, 8'h00, 0, 0, 0, 0));
        applyStimulus(1, 1, 8'hAA, 3'd2, 1'b0, mk(0, 8'h00, 0, 0, 0, 0));
        checkOutput("reset_addr", int'(addr), 0);

        $display("[TB] single beat, go during DONE ignored");
        runBurst(8'h10, 3'd1, 0, 0, 0, 0, -1, NONE);
        checkOutput("t1_beats", beats_seen, 1);
        checkOutput("t1_ds", ds_seen, 1);
        checkOutput("t1_busy", busy_seen, 3);
        checkOutput("t1_addr_count", addr_seen.size(), 1);
        if (addr_seen.size() == 1) checkOutput("t1_addr", int'(addr_seen[0]), 'h10);

        $display("[TB] four beats with address wrap, go while busy");
        runBurst(8'hFE, 3'd4, 0, 0, 0, 0, 3, NONE);
        checkOutput("t2_beats", beats_seen, 4);
        checkOutput("t2_ds", ds_seen, 1);
        checkOutput("t2_busy", busy_seen, 9);
        checkOutput("t2_addr_count", addr_seen.size(), 4);
        if (addr_seen.size() == 4) begin
            checkOutput("t2_addr0", int'(addr_seen[0]), 'hFE);
            checkOutput("t2_addr1", int'(addr_seen[1]), 'hFF);
            checkOutput("t2_addr2", int'(addr_seen[2]), 'h00);
            checkOutput("t2_addr3", int'(addr_seen[3]), 'h01);
        end

        $display("[TB] wait-states on first beat");
        runBurst(8'h20, 3'd2, 3, 0, 0, 0, NONE, NONE);
        checkOutput("t3_beats", beats_seen, 2);
        checkOutput("t3_ds", ds_seen, 1);
        checkOutput("t3_err", err_seen, 0);
        checkOutput("t3_busy", busy_seen, 8);

        $display("[TB] one wait-state short of timeout");
        runBurst(8'h30, 3'd1, MAX_WAIT - 1, 0, 0, 0, NONE, NONE);
        checkOutput("t3b_ds", ds_seen, 1);
        checkOutput("t3b_err", err_seen, 0);
        checkOutput("t3b_busy", busy_seen, 17);

        $display("[TB] ws stuck high, timeout");
        runBurst(8'h40, 3'd2, 20, 0, 0, 0, NONE, NONE);
        checkOutput("t4_err", err_seen, 1);
        checkOutput("t4_ds", ds_seen, 0);
        checkOutput("t4_beats", beats_seen, 0);
        checkOutput("t4_busy", busy_seen, 17);

        $display("[TB] reset during second beat wait");
        runBurst(8'h50, 3'd2, 0, 3, 0, 0, NONE, 4);
        checkOutput("t5_ds", ds_seen, 0);
        checkOutput("t5_err", err_seen, 0);
        checkOutput("t5_beats", beats_seen, 1);
        checkOutput("t5_busy", busy_seen, 4);
        checkOutput("t5_addr", int'(addr), 0);
        runBurst(8'h60, 3'd1, 0, 0, 0, 0, NONE, NONE);
        checkOutput("t5_after_ds", ds_seen, 1);

        $display("[TB] zero beats and clamped beats");
        runBurst(8'h70, 3'd0, 0, 0, 0, 0, NONE, NONE);
        checkOutput("t6_zero_busy", busy_seen, 0);
        runBurst(8'h80, 3'd7, 0, 1, 0, 0, NONE, NONE);
        checkOutput("t6_clamp_beats", beats_seen, 4);
        checkOutput("t6_clamp_busy", busy_seen, 10);
        checkOutput("t6_clamp_ds", ds_seen, 1);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
